// File: rtl/kulisch_to_fp16.sv
// rtl/kulisch_to_fp16.sv - carry-save Kulisch accumulator read-out to IEEE-754 FP16 (RNE)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_valid / i_ready       input pair handshake (i_ready high only when idle)
//   i_sum_acc, i_carry_acc  carry-save accumulator pair, LSB weighs 2^-FWIDTH
//   o_valid / o_ready       result handshake, result held until accepted
//   o_result                FP16 result
//   o_exception             [1] overflow, [0] inexact
module kulisch_to_fp16 #(
    parameter int AWIDTH = 92,
    parameter int FWIDTH = 48,
    parameter int DWIDTH = 16,
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [AWIDTH-1:0] i_sum_acc,
    input  logic [AWIDTH-1:0] i_carry_acc,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DWIDTH-1:0] o_result,
    output logic [1:0]        o_exception
);
    localparam int PW     = $clog2(AWIDTH + 1);
    localparam int BIAS   = (1 << (EWIDTH - 1)) - 1;
    localparam int P_MAX  = FWIDTH + BIAS;          // highest leading-one position that stays finite
    localparam int P_MIN  = FWIDTH - BIAS + 1;      // lowest leading-one position that is normal
    localparam int SUB_SH = FWIDTH - (BIAS - 1) - MWIDTH; // weight of the subnormal mantissa LSB
    localparam int EMW    = EWIDTH + MWIDTH;

    typedef enum logic [2:0] {IDLE, ADD, NORM, RND, HOLD} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] sum_q, carry_q, v_q;
    logic              sign_q, zero_q, ovf_q, guard_q, sticky_q;
    logic [EMW-1:0]    em_q;
    logic              ready_q, valid_q;
    logic [DWIDTH-1:0] result_q;
    logic [1:0]        exc_q;

    logic              accept;
    assign accept = i_valid && ready_q;

    // Normalisation of the resolved value held in v_q.
    logic              n_sign, n_zero, n_ovf, n_sub, n_guard, n_sticky;
    logic [AWIDTH-1:0] mag, aligned;
    logic [PW-1:0]     lead, shamt;
    logic [EWIDTH-1:0] exp_biased;
    logic [EMW-1:0]    n_em;

    always_comb begin
        n_sign = v_q[AWIDTH-1];
        // Magnitude fits in AWIDTH unsigned bits, so the most negative value is representable.
        mag    = n_sign ? (~v_q + 1'b1) : v_q;
        n_zero = (mag == '0);
        lead   = '0;
        for (int i = 0; i < AWIDTH; i++) begin
            if (mag[i]) lead = PW'(i);
        end
        // Shift the leading one out of the top so the mantissa starts at the MSB.
        shamt      = PW'(AWIDTH) - lead;
        aligned    = mag << shamt;
        exp_biased = EWIDTH'(lead - PW'(FWIDTH - BIAS));
        n_ovf      = lead > PW'(P_MAX);
        n_sub      = lead < PW'(P_MIN);
        if (n_sub) begin
            n_em     = {{EWIDTH{1'b0}}, mag[SUB_SH +: MWIDTH]};
            n_guard  = mag[SUB_SH-1];
            n_sticky = |mag[SUB_SH-2:0];
        end else begin
            n_em     = {exp_biased, aligned[AWIDTH-1 -: MWIDTH]};
            n_guard  = aligned[AWIDTH-1-MWIDTH];
            n_sticky = |aligned[AWIDTH-2-MWIDTH:0];
        end
    end

    // Rounding: adding the round bit to {exponent, mantissa} carries naturally into the
    // exponent, which covers subnormal->normal promotion and normal->infinity overflow.
    logic              round_up;
    logic [EMW-1:0]    em_rnd;
    logic [DWIDTH-1:0] r_result;
    logic [1:0]        r_exc;

    always_comb begin
        round_up = guard_q & (sticky_q | em_q[0]);
        em_rnd   = em_q + {{(EMW-1){1'b0}}, round_up};
        r_result = {sign_q, em_rnd};
        r_exc    = {1'b0, guard_q | sticky_q};
        if (zero_q) begin
            r_result = '0;
            r_exc    = 2'b00;
        end else if (ovf_q || (&em_rnd[EMW-1 -: EWIDTH])) begin
            r_result = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            r_exc    = 2'b11;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = RND;
            RND:     state_nxt = HOLD;
            HOLD:    if (o_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 2'b00;
            sum_q    <= '0;
            carry_q  <= '0;
            v_q      <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            em_q     <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (state == IDLE && accept) begin
                sum_q   <= i_sum_acc;
                carry_q <= i_carry_acc;
            end
            if (state == ADD) v_q <= sum_q + carry_q;
            if (state == NORM) begin
                sign_q   <= n_sign;
                zero_q   <= n_zero;
                ovf_q    <= n_ovf;
                em_q     <= n_em;
                guard_q  <= n_guard;
                sticky_q <= n_sticky;
            end
            if (state == RND) begin
                result_q <= r_result;
                exc_q    <= r_exc;
                valid_q  <= 1'b1;
            end
            if (state == HOLD && o_ready) valid_q <= 1'b0;
        end
    end

    assign i_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_exception = exc_q;
endmodule

// File: tb/tb_kulisch_to_fp16.sv
// tb/tb_kulisch_to_fp16.sv - self-checking bench for kulisch_to_fp16
module tb_kulisch_to_fp16;
    localparam int AW = 92;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b0;
    logic          i_ready, o_valid;
    logic [AW-1:0] i_sum_acc = '0;
    logic [AW-1:0] i_carry_acc = '0;
    logic [15:0]   o_result;
    logic [1:0]    o_exception;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [1:0]  exc;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] s;
        logic [AW-1:0] c;
        logic [15:0]   r;
        logic [1:0]    x;
    } vec_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kulisch_to_fp16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_sum_acc   (i_sum_acc),
        .i_carry_acc (i_carry_acc),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_result    (o_result),
        .o_exception (o_exception)
    );

    function automatic vec_t mk(input logic [AW-1:0] s, input logic [AW-1:0] c,
                                input logic [15:0] r, input logic [1:0] x);
        vec_t v;
        v.s = s; v.c = c; v.r = r; v.x = x;
        return v;
    endfunction

    // Called on a negedge; returns on the negedge right after the accepting edge.
    task automatic send(input vec_t v);
        int   n = 0;
        exp_t e;
        while (i_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (i_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: i_ready=%b required 1", i_ready);
        end
        i_valid = 1'b1;
        i_sum_acc = v.s;
        i_carry_acc = v.c;
        e.res = v.r;
        e.exc = v.x;
        sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0;
        i_sum_acc = AW'({$urandom(), $urandom(), $urandom()});
        i_carry_acc = AW'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({i_ready, o_valid, o_result, o_exception} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b res=%h exc=%b required 0/0/0000/00",
                     i_ready, o_valid, o_result, o_exception);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: i_ready=%b required 0", i_ready);
        end
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: i_ready=%b required 1", i_ready);
        end
    endtask

    task automatic test_conversions();
        vec_t tbl[$];
        vec_t v;
        exp_t e;
        int   n;
        logic [AW-1:0] one = AW'(1);
        tbl.push_back(mk(one << 48, '0, 16'h3C00, 2'b00));
        tbl.push_back(mk(one << 47, one << 47, 16'h3C00, 2'b00));
        tbl.push_back(mk(-(AW'(3) << 47), '0, 16'hBE00, 2'b00));
        tbl.push_back(mk((one << 48) + (one << 37), '0, 16'h3C00, 2'b01));
        tbl.push_back(mk((one << 48) + (AW'(3) << 37), '0, 16'h3C02, 2'b01));
        tbl.push_back(mk(AW'(65504) << 48, '0, 16'h7BFF, 2'b00));
        tbl.push_back(mk(AW'(65520) << 48, '0, 16'h7C00, 2'b11));
        tbl.push_back(mk(-(one << 70), '0, 16'hFC00, 2'b11));
        tbl.push_back(mk(one << 91, '0, 16'hFC00, 2'b11));
        tbl.push_back(mk(one << 34, '0, 16'h0400, 2'b00));
        tbl.push_back(mk(one << 24, '0, 16'h0001, 2'b00));
        tbl.push_back(mk(one << 23, '0, 16'h0000, 2'b01));
        tbl.push_back(mk(AW'(3) << 23, '0, 16'h0002, 2'b01));
        tbl.push_back(mk((AW'(1023) << 24) + (one << 23), '0, 16'h0400, 2'b01));
        tbl.push_back(mk(AW'(5), -AW'(5), 16'h0000, 2'b00));
        tbl.push_back(mk(-(one << 23), '0, 16'h8000, 2'b01));
        foreach (tbl[k]) begin
            v = tbl[k];
            send(v);
            wait_valid(n);
            checks++;
            if (n != 3) begin
                errors++;
                $display("FAIL conv%0d_latency: edges=%0d required 3", k, n);
            end
            o_ready = 1'b1;
            e = sb.pop_front();
            checks++;
            if (o_result !== e.res || o_exception !== e.exc) begin
                errors++;
                $display("FAIL conv%0d_result: got %h/%b required %h/%b",
                         k, o_result, o_exception, e.res, e.exc);
            end
            @(negedge clk);
            o_ready = 1'b0;
            checks++;
            if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
                errors++;
                $display("FAIL conv%0d_release: vld=%b rdy=%b required 0/1", k, o_valid, i_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        int   bad = 0;
        send(mk((AW'(1) << 48) + (AW'(3) << 37), '0, 16'h3C02, 2'b01));
        wait_valid(n);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_result !== e.res || o_exception !== e.exc)
                bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: unstable cycles=%0d required 0 (res=%h required %h)",
                     bad, o_result, e.res);
        end
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0/1", o_valid, i_ready);
        end
    endtask

    task automatic test_back_to_back();
        vec_t vv[3];
        exp_t e;
        int   n;
        int   last = 0;
        vv[0] = mk(AW'(1) << 48, '0, 16'h3C00, 2'b00);
        vv[1] = mk(-(AW'(3) << 47), '0, 16'hBE00, 2'b00);
        vv[2] = mk(AW'(3) << 23, '0, 16'h0002, 2'b01);
        o_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(vv[k]);
            if (k > 0) begin
                checks++;
                if (cyc - last != 5) begin
                    errors++;
                    $display("FAIL b2b%0d_spacing: cycles=%0d required 5", k, cyc - last);
                end
            end
            last = cyc;
            wait_valid(n);
            e = sb.pop_front();
            checks++;
            if (o_valid !== 1'b1 || o_result !== e.res || o_exception !== e.exc) begin
                errors++;
                $display("FAIL b2b%0d_result: vld=%b got %h/%b required %h/%b",
                         k, o_valid, o_result, o_exception, e.res, e.exc);
            end
        end
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        int   stale = 0;
        send(mk(AW'(65504) << 48, '0, 16'h7BFF, 2'b00));
        @(negedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if ({i_ready, o_valid, o_result, o_exception} !== 20'h0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b res=%h exc=%b required 0/0/0000/00",
                     i_ready, o_valid, o_result, o_exception);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: o_valid high cycles=%0d required 0", stale);
        end
        send(mk((AW'(1023) << 24) + (AW'(1) << 23), '0, 16'h0400, 2'b01));
        wait_valid(n);
        e = sb.pop_front();
        checks++;
        if (n != 3 || o_result !== e.res || o_exception !== e.exc) begin
            errors++;
            $display("FAIL midreset_next: edges=%0d got %h/%b required 3 %h/%b",
                     n, o_result, o_exception, e.res, e.exc);
        end
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kulisch_to_fp16.md
Name: kulisch_to_fp16

Overview:
- Read-out end of the Kulisch accumulation path.
- Takes the carry-save wide fixed-point accumulator pair produced by the Kulisch accumulator, resolves it to a single value, normalizes it and rounds it to an IEEE-754 FP16 result.
- Multi-cycle FSM with a valid/ready handshake on both sides. One conversion in flight at a time.
- Sits between the tensor-core MMA accumulator and the FP16 write-back path.

Parameters:
- AWIDTH, 92, accumulator width: 1 sign + 11 headroom + 32 integer + 48 fraction bits.
- FWIDTH, 48, fraction bits; the accumulator LSB weighs 2^-FWIDTH.
- DWIDTH, 16, FP16 result width.
- EWIDTH, 5, FP16 exponent width.
- MWIDTH, 10, FP16 mantissa width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- i_valid, input, 1, input pair valid.
- i_ready, output, 1, block can accept an input pair.
- i_sum_acc, input, AWIDTH, accumulator sum vector.
- i_carry_acc, input, AWIDTH, accumulator carry vector.
- o_valid, output, 1, result valid.
- o_ready, input, 1, consumer accepts the result.
- o_result, output, DWIDTH, FP16 result.
- o_exception, output, 2, [1] overflow, [0] inexact.

Behaviour:
- Reset: the single clock is clk. Reset is asynchronous and active-low on rst_n. While rst_n is low: state=IDLE, i_ready=0, o_valid=0, o_result=16'h0000, o_exception=2'b00. i_ready goes to 1 on the first edge after rst_n deasserts. Reset mid-conversion discards the operation; no output is produced.
- FSM states: IDLE, ADD, NORM, RND, HOLD. i_ready=1 only in IDLE.
- IDLE: on i_valid&&i_ready, register both vectors and go to ADD.
- ADD: V = (sum+carry) mod 2^AWIDTH, read as two's complement. Register V, go to NORM.
- NORM:
  - s = V[AWIDTH-1]; M = |V| as an AWIDTH-bit unsigned value, so -2^91 is legal.
  - Leading-one position p; unbiased exponent e = p - FWIDTH.
  - Left-align M to the leading one. Keep 10 mantissa bits, a guard bit, and a sticky bit (OR of all lower bits).
  - Go to RND.
- RND: round-to-nearest-even only, with these cases:
  - M==0: result 16'h0000 (always +0), exc 00.
  - e>15: result {s,5'h1F,10'h0} (infinity), exc 11.
  - -14<=e<=15: E = e+15; mantissa rounded by RNE. A rounding carry increments E; if E reaches 31, result is infinity with exc 11.
  - e<-14 (subnormal): mantissa = RNE(M / 2^(FWIDTH-24)). A rounded value of 1024 yields {s,5'h01,10'h0}. A rounded value of 0 yields {s,15'h0}.
  - Inexact is set whenever guard|sticky is 1.
  - Register o_result/o_exception, set o_valid=1, go to HOLD.
- HOLD: o_result, o_exception and o_valid are held stable until o_ready=1. On o_valid&&o_ready, clear o_valid and go to IDLE.
- Latency: o_valid rises on the 3rd rising edge after the accepting edge. Minimum spacing between accepts is 5 cycles.
- i_sum_acc/i_carry_acc are sampled only on the accepting edge; changes at other times are ignored.

Test Plan:
- sum=1<<48, carry=0 -> o_result=16'h3C00, exc=00; o_valid exactly 3 edges after accept.
- sum=1<<47, carry=1<<47 (carry-save 1.0) -> 16'h3C00. sum = two's complement of (3<<47), carry=0 (-1.5) -> 16'hBE00, exc=00.
- RNE ties:
  - (1<<48)+(1<<37) (1+2^-11) -> 16'h3C00, exc=01.
  - (1<<48)+(3<<37) -> 16'h3C02, exc=01.
  - 65504<<48 -> 16'h7BFF, exc=00.
  - 65520<<48 -> 16'h7C00, exc=11.
  - -(1<<70) -> 16'hFC00, exc=11.
- Subnormals:
  - 1<<24 -> 16'h0001, exc=00.
  - 1<<23 -> 16'h0000, exc=01.
  - 3<<23 -> 16'h0002, exc=01.
  - ((1<<10)-1)<<24 plus 1<<23 -> 16'h0400, exc=01.
  - sum=5, carry=-5 -> 16'h0000, exc=00.
- Backpressure: hold o_ready=0 for 10 cycles -> o_valid and o_result stable, i_ready=0 throughout. Raise o_ready -> o_valid drops next edge, i_ready=1.
- Drop rst_n while in NORM -> all outputs reset immediately (async). After release, no stale o_valid appears, and the next conversion is correct.
